// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALTED sequencer and IF/ID pipeline register.
// Optional macro FETCH_MISALIGN_CHK_EN aligns redirect targets and raises a sticky misalign flag.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'hBFC00000,
    parameter int          A_LENGTH  = 12,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                pc_src,
    input  logic [31:0]         pc_target,
    input  logic                halt,
    output logic [A_LENGTH-1:0] imem_addr,
    input  logic [31:0]         imem_rd,
    output logic [31:0]         instr_d,
    output logic [31:0]         pc_d,
    output logic [31:0]         pc_plus4_d,
    output logic                valid_d,
    output logic                misalign,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc_f;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

    assign w_pc_plus4 = r_pc_f + 32'd4;

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_misalign;
    logic w_target_misaligned;
    assign w_target_misaligned = (pc_target[1:0] != 2'b00);
    assign w_target            = {pc_target[31:2], 2'b00};
    assign misalign            = r_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (r_state == RUN && pc_src && w_target_misaligned) begin
            r_misalign <= 1'b1;
        end
    end
`else
    assign w_target = pc_target;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= BOOT;
            r_pc_f       <= RESET_PC;
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= RESET_PC;
            r_pc_plus4_d <= RESET_PC + 32'd4;
            r_valid_d    <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state   <= RUN;
                    r_instr_d <= NOP_INSTR;
                    r_valid_d <= 1'b0;
                end
                RUN: begin
                    if (halt) begin
                        r_state <= HALTED;
                    end
                    // A redirect wins over stall so it is never dropped.
                    if (pc_src) begin
                        r_pc_f <= w_target;
                    end else if (!stall) begin
                        r_pc_f <= w_pc_plus4;
                    end
                    if (flush) begin
                        r_instr_d    <= NOP_INSTR;
                        r_valid_d    <= 1'b0;
                        r_pc_d       <= r_pc_f;
                        r_pc_plus4_d <= w_pc_plus4;
                    end else if (!stall) begin
                        r_instr_d    <= imem_rd;
                        r_valid_d    <= 1'b1;
                        r_pc_d       <= r_pc_f;
                        r_pc_plus4_d <= w_pc_plus4;
                    end
                end
                HALTED: begin
                    r_instr_d <= NOP_INSTR;
                    r_valid_d <= 1'b0;
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

    assign imem_addr  = r_pc_f[A_LENGTH-1:0];
    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc_plus4_d = r_pc_plus4_d;
    assign valid_d    = r_valid_d;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vectors push expectations into a queue,
// a negedge monitor pops and compares them against the IF/ID outputs.
module tb_fetch_stage;

    localparam logic [31:0] B    = 32'hBFC00000;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [1:0]  S_BOOT = 2'd0;
    localparam logic [1:0]  S_RUN  = 2'd1;
    localparam logic [1:0]  S_HALT = 2'd2;
`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic [31:0] MIS_PC   = B + 32'h104;
    localparam logic [11:0] MIS_ADDR = 12'h104;
    localparam logic        MIS_FLAG = 1'b1;
`else
    localparam logic [31:0] MIS_PC   = B + 32'h106;
    localparam logic [11:0] MIS_ADDR = 12'h106;
    localparam logic        MIS_FLAG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, pc_src, halt;
    logic [31:0] pc_target;
    logic [11:0] imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d, misalign;
    logic [1:0]  dbg_state;

    // Second instance booting at the top of the address space.
    logic [11:0] b_addr;
    logic [31:0] b_rd, b_instr, b_pc, b_pc4;
    logic        b_valid, b_mis;
    logic [1:0]  b_state;

    assign imem_rd = {20'h0, imem_addr};
    assign b_rd    = {20'h0, b_addr};

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pc_src(pc_src),
        .pc_target(pc_target), .halt(halt), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
        .misalign(misalign), .dbg_state(dbg_state)
    );

    fetch_stage #(.RESET_PC(32'hFFFFFFFC)) dut_b (
        .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0), .pc_src(1'b0),
        .pc_target(32'h0), .halt(1'b0), .imem_addr(b_addr), .imem_rd(b_rd),
        .instr_d(b_instr), .pc_d(b_pc), .pc_plus4_d(b_pc4), .valid_d(b_valid),
        .misalign(b_mis), .dbg_state(b_state)
    );

    always #5 clk = ~clk;

    int cyc = -1;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        bit          chk_ins;
        bit          chk_pc;
        bit          chk_ctl;
        bit          chk_b;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic [11:0] addr;
        logic        mis;
        logic [1:0]  st;
        logic [31:0] pc_b;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got %h required %h", name, field, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL %s.stale: checked at cycle %0d required %0d", e.name, cyc, e.cyc);
            end else begin
                if (e.chk_ins) begin
                    cmp(e.name, "instr_d", instr_d, e.instr);
                    cmp(e.name, "valid_d", {31'h0, valid_d}, {31'h0, e.valid});
                end
                if (e.chk_pc) begin
                    cmp(e.name, "pc_d", pc_d, e.pc);
                    cmp(e.name, "pc_plus4_d", pc_plus4_d, e.pc + 32'd4);
                end
                if (e.chk_ctl) begin
                    cmp(e.name, "imem_addr", {20'h0, imem_addr}, {20'h0, e.addr});
                    cmp(e.name, "misalign", {31'h0, misalign}, {31'h0, e.mis});
                    cmp(e.name, "state", {30'h0, dbg_state}, {30'h0, e.st});
                end
                if (e.chk_b) begin
                    cmp(e.name, "b_pc_d", b_pc, e.pc_b);
                    cmp(e.name, "b_pc_plus4_d", b_pc4, e.pc_b + 32'd4);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic f, input logic p,
                          input logic [31:0] t, input logic h);
        stall = s; flush = f; pc_src = p; pc_target = t; halt = h;
    endtask

    task automatic ex(input string name, input logic [31:0] instr, input logic [31:0] pc,
                      input logic valid, input logic [11:0] addr, input logic [1:0] st,
                      input logic mis);
        exp_t e;
        e = '{cyc: cyc, name: name, chk_ins: 1'b1, chk_pc: 1'b1, chk_ctl: 1'b1, chk_b: 1'b0,
              instr: instr, pc: pc, valid: valid, addr: addr, mis: mis, st: st, pc_b: 32'h0};
        exp_q.push_back(e);
    endtask

    task automatic exh(input string name, input logic [11:0] addr, input logic mis);
        exp_t e;
        e = '{cyc: cyc, name: name, chk_ins: 1'b1, chk_pc: 1'b0, chk_ctl: 1'b1, chk_b: 1'b0,
              instr: NOP, pc: 32'h0, valid: 1'b0, addr: addr, mis: mis, st: S_HALT, pc_b: 32'h0};
        exp_q.push_back(e);
    endtask

    task automatic exb(input string name, input logic [31:0] pcb);
        exp_t e;
        e = '{cyc: cyc, name: name, chk_ins: 1'b0, chk_pc: 1'b0, chk_ctl: 1'b0, chk_b: 1'b1,
              instr: 32'h0, pc: 32'h0, valid: 1'b0, addr: 12'h0, mis: 1'b0, st: 2'd0, pc_b: pcb};
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d checks pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 32'h0, 0);
        tick(); ex("reset", NOP, B, 0, 12'h000, S_BOOT, 0);
        rst = 1'b0;
        tick(); ex("boot", NOP, B, 0, 12'h000, S_RUN, 0);
        tick(); ex("first_fetch", 32'h000, B, 1, 12'h004, S_RUN, 0); exb("wrap_b0", 32'hFFFFFFFC);
        tick(); ex("seq_4", 32'h004, B + 32'h4, 1, 12'h008, S_RUN, 0); exb("wrap_b1", 32'h0);
        tick(); ex("seq_8", 32'h008, B + 32'h8, 1, 12'h00C, S_RUN, 0);
        tick(); ex("seq_c", 32'h00C, B + 32'hC, 1, 12'h010, S_RUN, 0);

        set_in(1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); ex("stall", 32'h00C, B + 32'hC, 1, 12'h010, S_RUN, 0);
        end
        set_in(0, 0, 0, 32'h0, 0);
        tick(); ex("resume", 32'h010, B + 32'h10, 1, 12'h014, S_RUN, 0);

        set_in(1, 1, 1, B + 32'h100, 0);
        tick(); ex("redir_flush_stall", NOP, B + 32'h14, 0, 12'h100, S_RUN, 0);
        set_in(0, 0, 0, 32'h0, 0);
        tick(); ex("redir_land", 32'h100, B + 32'h100, 1, 12'h104, S_RUN, 0);

        set_in(1, 0, 1, B + 32'hFFC, 0);
        tick(); ex("redir_in_stall", 32'h100, B + 32'h100, 1, 12'hFFC, S_RUN, 0);
        set_in(0, 0, 0, 32'h0, 0);
        tick(); ex("fetch_ffc", 32'hFFC, B + 32'hFFC, 1, 12'h000, S_RUN, 0);
        tick(); ex("fetch_1000", 32'h000, B + 32'h1000, 1, 12'h004, S_RUN, 0);

        set_in(0, 1, 0, 32'h0, 0);
        tick(); ex("flush", NOP, B + 32'h1004, 0, 12'h008, S_RUN, 0);

        set_in(0, 0, 1, B + 32'h106, 0);
        tick(); ex("misalign_redir", 32'h008, B + 32'h1008, 1, MIS_ADDR, S_RUN, MIS_FLAG);
        set_in(0, 0, 1, B + 32'h20, 0);
        tick(); ex("redir_20", {20'h0, MIS_ADDR}, MIS_PC, 1, 12'h020, S_RUN, MIS_FLAG);

        set_in(0, 0, 0, 32'h0, 1);
        tick(); ex("halt_latch", 32'h020, B + 32'h20, 1, 12'h024, S_HALT, MIS_FLAG);
        set_in(1, 1, 1, B + 32'h200, 1);
        tick(); exh("halted_0", 12'h024, MIS_FLAG);
        set_in(0, 0, 1, B + 32'h300, 0);
        tick(); exh("halted_1", 12'h024, MIS_FLAG);

        rst = 1'b1;
        set_in(1, 1, 1, B + 32'h400, 1);
        tick(); ex("reset_from_halt", NOP, B, 0, 12'h000, S_BOOT, 0);
        rst = 1'b0;
        set_in(0, 0, 0, 32'h0, 0);
        tick(); ex("boot2", NOP, B, 0, 12'h000, S_RUN, 0);
        tick(); ex("refetch", 32'h000, B, 1, 12'h004, S_RUN, 0);

        tick();
        tick();
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending checks required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, boot address loaded into the PC on reset.
REQ-002 Parameter A_LENGTH, default 12, width of the instruction-memory byte address.
REQ-003 Parameter NOP_INSTR, default 32'h00000013, instruction word inserted as a bubble.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 stall  input  1  hazard stall; hold PC and IF/ID register.
REQ-007 flush  input  1  squash the instruction entering IF/ID.
REQ-008 pc_src  input  1  redirect request (taken branch/jump).
REQ-009 pc_target  input  32  redirect target address.
REQ-010 halt  input  1  stop fetching until next reset.
REQ-011 imem_addr  output  A_LENGTH  byte address to the combinational instruction memory.
REQ-012 imem_rd  input  32  little-endian instruction word returned the same cycle.
REQ-013 instr_d  output  32  registered instruction to decode.
REQ-014 pc_d  output  32  registered PC of instr_d.
REQ-015 pc_plus4_d  output  32  registered pc_d+4.
REQ-016 valid_d  output  1  instr_d is a real fetched instruction.
REQ-017 misalign  output  1  sticky misaligned-redirect flag.

Function
REQ-018 Internal PC register pc_f SHALL drive imem_addr = pc_f[A_LENGTH-1:0] combinationally; memory latency is zero cycles, the fetch-to-decode latency is one cycle.
REQ-019 FSM states SHALL be BOOT, RUN, HALTED; rst forces BOOT; BOOT -> RUN unconditionally next cycle; RUN -> HALTED when halt=1; HALTED exits only on rst.
REQ-020 In BOOT: pc_f holds RESET_PC, IF/ID loads NOP_INSTR with valid_d=0.
REQ-021 In RUN with stall=0, flush=0: IF/ID loads instr_d=imem_rd, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1.
REQ-022 In RUN, next pc_f SHALL be pc_target when pc_src=1, else pc_f when stall=1, else pc_f+4.
REQ-023 pc_src SHALL override stall: a redirect is never lost while stalled.
REQ-024 flush=1 SHALL load instr_d=NOP_INSTR, valid_d=0, regardless of stall; pc_d/pc_plus4_d load as in REQ-021.
REQ-025 stall=1 with flush=0 SHALL hold instr_d, pc_d, pc_plus4_d, valid_d unchanged.
REQ-026 PC arithmetic SHALL be modulo 2^32 (32'hFFFFFFFC+4 = 0); imem_addr wraps within the 2^A_LENGTH window (offset 12'hFFC -> 12'h000).
REQ-027 On halt in RUN, the instruction currently fetched SHALL still be latched (if not stalled/flushed); from HALTED onward pc_f freezes, valid_d=0, instr_d=NOP_INSTR, stall/flush/pc_src ignored.

Reset
REQ-028 rst=1 at a clock edge SHALL set pc_f=RESET_PC, state=BOOT, instr_d=NOP_INSTR, pc_d=RESET_PC, pc_plus4_d=RESET_PC+4, valid_d=0, misalign=0.
REQ-029 rst SHALL take priority over every other input, including mid-stall, mid-redirect and HALTED.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHK_EN, when defined: a redirect with pc_target[1:0]!=0 SHALL set misalign=1 (sticky until rst) and load pc_f={pc_target[31:2],2'b00}.
REQ-031 Without FETCH_MISALIGN_CHK_EN: misalign SHALL be constant 0 and pc_target loads unmodified.

Verification
REQ-032 rst 1 cycle, then free run with imem returning A as data -> cycle1 valid_d=0; cycle2 pc_d=32'hBFC00000, valid_d=1; cycle3 pc_d=32'hBFC00004.
REQ-033 stall=1 for 3 cycles in RUN at pc_f=32'hBFC00010 -> imem_addr stays 12'h010, IF/ID outputs unchanged; resume -> pc_d=32'hBFC00010 next.
REQ-034 pc_src=1, pc_target=32'hBFC00100, flush=1, stall=1 same cycle -> next cycle valid_d=0, instr_d=32'h00000013, imem_addr=12'h100.
REQ-035 pc_f=32'hBFC00FFC, no stall -> next imem_addr=12'h000, pc_f=32'hBFC01000; RESET_PC=32'hFFFFFFFC run -> pc_f wraps to 0.
REQ-036 halt=1 in RUN at pc_f=32'hBFC00020 -> pc_d=32'hBFC00020 valid_d=1 once, then valid_d=0, pc_f frozen until rst; rst returns to BOOT with pc_f=32'hBFC00000.
REQ-037 With FETCH_MISALIGN_CHK_EN, pc_target=32'hBFC00106 -> misalign=1 sticky, imem_addr=12'h104; without macro -> misalign=0, imem_addr=12'h106.
